// File: rtl/cc_speed_scheduler.sv
// Game-speed time base: programmable base counter, per-lane tick dividers and start/pause/level-up/game-over sequencing.
// Defining CC_SPEEDSCHEDULER_TICKCOUNT_EN adds a 16-bit lane-0 tick counter output.
module cc_speed_scheduler #(
   parameter int DATAWIDTH   = 23,
   parameter int NUM_LANES   = 4,
   parameter int BASE_PERIOD = 8480,
   parameter int MAX_LEVEL   = 3
) (
   input  logic                 CC_SPEEDSCHEDULER_CLOCK_50,
   input  logic                 CC_SPEEDSCHEDULER_RESET_InLow,
   input  logic                 CC_SPEEDSCHEDULER_start_InHigh,
   input  logic                 CC_SPEEDSCHEDULER_pause_InHigh,
   input  logic                 CC_SPEEDSCHEDULER_levelup_InHigh,
   input  logic                 CC_SPEEDSCHEDULER_gameover_InHigh,
   output logic [NUM_LANES-1:0] CC_SPEEDSCHEDULER_tick_OutLowBUS,
   output logic [1:0]           CC_SPEEDSCHEDULER_level_OutBUS,
   output logic                 CC_SPEEDSCHEDULER_running_OutHigh
`ifdef CC_SPEEDSCHEDULER_TICKCOUNT_EN
   ,
   output logic [15:0]          CC_SPEEDSCHEDULER_tickcount_OutBUS
`endif
);

   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LEVELUP} state_t;

   state_t state, state_next;

   logic clk, rst_n, start, pause, levelup, gameover;
   assign clk      = CC_SPEEDSCHEDULER_CLOCK_50;
   assign rst_n    = CC_SPEEDSCHEDULER_RESET_InLow;
   assign start    = CC_SPEEDSCHEDULER_start_InHigh;
   assign pause    = CC_SPEEDSCHEDULER_pause_InHigh;
   assign levelup  = CC_SPEEDSCHEDULER_levelup_InHigh;
   assign gameover = CC_SPEEDSCHEDULER_gameover_InHigh;

   logic [DATAWIDTH-1:0] base_cnt, period;
   logic [LANE_W-1:0]    lane_cnt [NUM_LANES];
   logic [1:0]           level_q;
   logic [NUM_LANES-1:0] fire;
   logic                 count_en, clear, base_tick, start_acc, level_acc;

   // NOTE: next state gets its default before the case so every path assigns it and no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (start) state_next = S_RUN;
         S_RUN: begin
            if (gameover)     state_next = S_IDLE;
            else if (levelup) state_next = S_LEVELUP;
            else if (pause)   state_next = S_PAUSE;
         end
         S_PAUSE: begin
            if (gameover)     state_next = S_IDLE;
            else if (!pause)  state_next = S_RUN;
         end
         S_LEVELUP: state_next = S_RUN;
         default:   state_next = S_IDLE;
      endcase
   end

   // The resume edge out of PAUSE counts, so a pause of N cycles shifts ticks by exactly N.
   assign count_en  = (state_next == S_RUN) && ((state == S_RUN) || (state == S_PAUSE));
   assign clear     = (state_next == S_IDLE) || (state_next == S_LEVELUP);
   assign start_acc = (state == S_IDLE) && start;
   assign level_acc = (state == S_RUN) && (state_next == S_LEVELUP);
   assign period    = DATAWIDTH'(BASE_PERIOD) >> level_q;
   assign base_tick = count_en && (base_cnt == period - DATAWIDTH'(1));

   always_comb begin
      fire = '0;
      for (int i = 0; i < NUM_LANES; i++)
         fire[i] = base_tick && (lane_cnt[i] == LANE_W'(i));
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        base_cnt <= '0;
      else if (clear)    base_cnt <= '0;
      else if (count_en) base_cnt <= base_tick ? '0 : base_cnt + DATAWIDTH'(1);
   end

   // NOTE: lane counters are a handful of control flops, not a RAM, so each one is reset explicitly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_LANES; i++) lane_cnt[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < NUM_LANES; i++) lane_cnt[i] <= '0;
      end else if (base_tick) begin
         for (int i = 0; i < NUM_LANES; i++)
            lane_cnt[i] <= (lane_cnt[i] == LANE_W'(i)) ? '0 : lane_cnt[i] + LANE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         level_q <= '0;
      else if (start_acc) level_q <= '0;
      else if (level_acc) level_q <= (level_q == 2'(MAX_LEVEL)) ? level_q : level_q + 2'd1;
   end

   // fire is only ever set on an edge that stays in RUN, so every other edge drives the bus high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         CC_SPEEDSCHEDULER_tick_OutLowBUS  <= '1;
         CC_SPEEDSCHEDULER_running_OutHigh <= 1'b0;
      end else begin
         CC_SPEEDSCHEDULER_tick_OutLowBUS  <= ~fire;
         CC_SPEEDSCHEDULER_running_OutHigh <= (state_next == S_RUN);
      end
   end

   assign CC_SPEEDSCHEDULER_level_OutBUS = level_q;

`ifdef CC_SPEEDSCHEDULER_TICKCOUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         CC_SPEEDSCHEDULER_tickcount_OutBUS <= '0;
      else if (start_acc) CC_SPEEDSCHEDULER_tickcount_OutBUS <= '0;
      else if (fire[0])   CC_SPEEDSCHEDULER_tickcount_OutBUS <= CC_SPEEDSCHEDULER_tickcount_OutBUS + 16'd1;
   end
`endif

endmodule

// File: tb/tb_cc_speed_scheduler.sv
// Self-checking bench for cc_speed_scheduler: directed scenarios plus random control traffic
// checked every cycle against an elapsed-time reference model.
module tb_cc_speed_scheduler;

   localparam int NL = 4;
   localparam int BP = 16;
   localparam int ML = 3;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LVL = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0, pause = 1'b0, levelup = 1'b0, gameover = 1'b0;
   logic [NL-1:0] tick;
   logic [1:0]    level;
   logic          running;
`ifdef CC_SPEEDSCHEDULER_TICKCOUNT_EN
   logic [15:0]   tickcount;
`endif

   always #5 clk = ~clk;

   cc_speed_scheduler #(
      .DATAWIDTH(23), .NUM_LANES(NL), .BASE_PERIOD(BP), .MAX_LEVEL(ML)
   ) dut (
      .CC_SPEEDSCHEDULER_CLOCK_50        (clk),
      .CC_SPEEDSCHEDULER_RESET_InLow     (rst_n),
      .CC_SPEEDSCHEDULER_start_InHigh    (start),
      .CC_SPEEDSCHEDULER_pause_InHigh    (pause),
      .CC_SPEEDSCHEDULER_levelup_InHigh  (levelup),
      .CC_SPEEDSCHEDULER_gameover_InHigh (gameover),
      .CC_SPEEDSCHEDULER_tick_OutLowBUS  (tick),
      .CC_SPEEDSCHEDULER_level_OutBUS    (level),
      .CC_SPEEDSCHEDULER_running_OutHigh (running)
`ifdef CC_SPEEDSCHEDULER_TICKCOUNT_EN
      ,
      .CC_SPEEDSCHEDULER_tickcount_OutBUS(tickcount)
`endif
   );

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model: ticks derive from the number of counted cycles since the last clear.
   int            m_state, m_level, m_elapsed, m_running, m_tc;
   logic [NL-1:0] m_tick;

   // Cycle offset since the last clear_rec(), and offsets at which lanes 0/1/3 were seen low.
   int off;
   int q0[$], q1[$], q3[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = M_IDLE; m_level = 0; m_elapsed = 0; m_running = 0; m_tc = 0; m_tick = '1;
   endtask

   task automatic model_edge(input logic st, input logic pa, input logic lu, input logic go);
      int nxt, per;
      nxt = m_state;
      case (m_state)
         M_IDLE:  if (st) nxt = M_RUN;
         M_RUN:   if (go) nxt = M_IDLE; else if (lu) nxt = M_LVL; else if (pa) nxt = M_PAUSE;
         M_PAUSE: if (go) nxt = M_IDLE; else if (!pa) nxt = M_RUN;
         default: nxt = M_RUN;
      endcase
      per    = BP >> m_level;
      m_tick = '1;
      if (nxt == M_RUN && (m_state == M_RUN || m_state == M_PAUSE)) begin
         m_elapsed++;
         for (int i = 0; i < NL; i++)
            if (m_elapsed % ((i + 1) * per) == 0) m_tick[i] = 1'b0;
      end
      if (nxt == M_IDLE) m_elapsed = 0;
      if (m_state == M_RUN && nxt == M_LVL) begin
         m_elapsed = 0;
         m_level   = (m_level < ML) ? m_level + 1 : ML;
      end
      if (m_state == M_IDLE && nxt == M_RUN) begin
         m_level = 0;
         m_tc    = 0;
      end else if (!m_tick[0]) begin
         m_tc = (m_tc + 1) % 65536;
      end
      m_running = (nxt == M_RUN) ? 1 : 0;
      m_state   = nxt;
   endtask

   task automatic check_outputs();
      check("tick", tick, m_tick);
      check("level", level, m_level);
      check("running", running, m_running);
`ifdef CC_SPEEDSCHEDULER_TICKCOUNT_EN
      check("tickcount", tickcount, m_tc);
`endif
   endtask

   task automatic clear_rec();
      off = 0;
      q0.delete(); q1.delete(); q3.delete();
   endtask

   task automatic step(input logic st, input logic pa, input logic lu, input logic go);
      start = st; pause = pa; levelup = lu; gameover = go;
      @(posedge clk);
      model_edge(st, pa, lu, go);
      #1;
      check_outputs();
      off++;
      if (!tick[0]) q0.push_back(off);
      if (!tick[1]) q1.push_back(off);
      if (!tick[3]) q3.push_back(off);
   endtask

   function automatic int qat(input int q[$], input int k);
      return (q.size() > k) ? q[k] : -1;
   endfunction

   // Start from IDLE, then 70 quiet cycles: lane0 at 16/32/48/64, lane1 at 32/64, lane3 at 64.
   task automatic start_timing(input string tag);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check({tag, "_level"}, level, 0);
      clear_rec();
      repeat (70) step(1'b0, 1'b0, 1'b0, 1'b0);
      check({tag, "_l0_cnt"}, q0.size(), 4);
      for (int k = 0; k < 4; k++) check({tag, "_l0_at"}, qat(q0, k), BP * (k + 1));
      check({tag, "_l1_cnt"}, q1.size(), 2);
      check({tag, "_l1_at0"}, qat(q1, 0), 2 * BP);
      check({tag, "_l1_at1"}, qat(q1, 1), 4 * BP);
      check({tag, "_l3_cnt"}, q3.size(), 1);
      check({tag, "_l3_at0"}, qat(q3, 0), 4 * BP);
      check({tag, "_running"}, running, 1);
   endtask

   initial begin
      logic pl;
      model_reset();
      clear_rec();
      #2 rst_n = 1'b0;
      #1;
      check_outputs();
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Idle: gameover is ignored and nothing ticks.
      step(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

      start_timing("start");

      // Level-up: one non-running cycle, then period 8 from a cleared counter.
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check("lvlup_level", level, 1);
      check("lvlup_running", running, 0);
      clear_rec();
      repeat (40) step(1'b0, 1'b0, 1'b0, 1'b0);
      check("lvl1_first", qat(q0, 0), 9);
      check("lvl1_second", qat(q0, 1), 17);
      repeat (4) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);
      end
      check("lvl_saturate", level, ML);
      clear_rec();
      repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);
      check("lvl3_cnt", q0.size(), 5);
      check("lvl3_spacing", qat(q0, 1) - qat(q0, 0), 2);

      // Pause 20 cycles mid-period with a level-up pulse inside it.
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      clear_rec();
      repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (9) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0);
      check("pause_no_tick", q0.size(), 0);
      check("pause_level", level, 0);
      repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0);
      check("pause_shift", qat(q0, 0), BP + 20);

      // Pause on the terminal count: tick withheld, then issued on the resume cycle.
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (15) step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("tc_pause_notick", tick[0], 1);
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("tc_resume_tick", tick[0], 0);

      // Gameover together with level-up: gameover wins, level kept.
      step(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("go_lu_level", level, 1);
      check("go_lu_ticks", tick, 4'hF);
      check("go_lu_running", running, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("restart_level", level, 0);

      // Asynchronous reset in the middle of RUN.
      repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      start_timing("after_rst");

`ifdef CC_SPEEDSCHEDULER_TICKCOUNT_EN
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (10 * BP) step(1'b0, 1'b0, 1'b0, 1'b0);
      check("tickcount_10", tickcount, 10);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("tickcount_clear", tickcount, 0);
`endif

      // Random control traffic against the model.
      pl = 1'b0;
      repeat (3000) begin
         if ($urandom_range(0, 29) == 0) pl = ~pl;
         step($urandom_range(0, 19) == 0, pl, $urandom_range(0, 59) == 0, $urandom_range(0, 149) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
